// File: rtl/stopwatch_core.sv
// Stopwatch core: MM:SS.t BCD counter driven by tenth-second tick edges, start/stop and clear buttons.
// Latency: an input edge acts on the first clk edge that samples it (+2 cycles when TICK_SYNC=1).
// Backpressure: none; every event is consumed in the cycle it is detected.
module stopwatch_core #(
    parameter int TICK_SYNC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } state_t;

    // Inputs after optional synchronisation: {tick, start_stop, clear}
    logic [2:0] in_s;

    generate
        if (TICK_SYNC != 0) begin : g_sync
            logic [2:0] meta_q;
            logic [2:0] sync_q;

            // Two-flop synchroniser for asynchronous button/tick sources
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= {tick_in, start_stop, clear};
                    sync_q <= meta_q;
                end
            end

            assign in_s = sync_q;
        end else begin : g_nosync
            assign in_s = {tick_in, start_stop, clear};
        end
    endgenerate

    logic [2:0] edge_q;

    // Registered copy of each input; a rising edge is "high now, low last cycle"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= in_s;
        end
    end

    logic tick_ev;
    logic ss_ev;
    logic clr_ev;

    assign tick_ev = in_s[2] & ~edge_q[2];
    assign ss_ev   = in_s[1] & ~edge_q[1];
    assign clr_ev  = in_s[0] & ~edge_q[0];

    state_t     state_q;
    logic [3:0] tenths_q,   tenths_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [2:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [2:0] min_tens_q, min_tens_d;
    logic       running_q;
    logic       overflow_q;
    logic       at_max;

    // Count-plus-one-tenth with the full carry chain resolved in one cycle
    always_comb begin
        tenths_d   = tenths_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        at_max     = (min_tens_q == 3'd5) && (min_ones_q == 4'd9) &&
                     (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9) &&
                     (tenths_q == 4'd9);
        if (tenths_q != 4'd9) begin
            tenths_d = tenths_q + 4'd1;
        end else begin
            tenths_d = 4'd0;
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 3'd5) begin
                    sec_tens_d = sec_tens_q + 3'd1;
                end else begin
                    sec_tens_d = 3'd0;
                    if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        // At 5x:59.9 this only matters below 59; 59:59.9 is caught by at_max
                        min_tens_d = (min_tens_q == 3'd5) ? 3'd5 : min_tens_q + 3'd1;
                    end
                end
            end
        end
    end

    // Control FSM with digit registers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tenths_q   <= '0;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clr_ev) begin
            // Clear wins over every other event in every state
            state_q    <= ST_IDLE;
            tenths_q   <= '0;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A tick arriving with start is not counted
                    if (ss_ev) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick_ev && at_max) begin
                        // Hold 59:59.9; saturation outranks a simultaneous stop
                        state_q    <= ST_SAT;
                        running_q  <= 1'b0;
                        overflow_q <= 1'b1;
                    end else begin
                        if (tick_ev) begin
                            tenths_q   <= tenths_d;
                            sec_ones_q <= sec_ones_d;
                            sec_tens_q <= sec_tens_d;
                            min_ones_q <= min_ones_d;
                            min_tens_q <= min_tens_d;
                        end
                        if (ss_ev) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (ss_ev) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_SAT: begin
                    state_q <= ST_SAT;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign tenths   = tenths_q;
    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
